md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the EX stage of the five-stage pipeline, successor to the fixed 32-bit MDU. Holds the HI/LO register pair, executes signed/unsigned multiply, divide, multiply-accumulate and multiply-subtract with configurable latencies, and supports direct HI/LO writes. Adds an in-flight cancel for pipeline flush and defined divide-by-zero and overflow behaviour. Busy/start semantics stay compatible with the existing stall logic.

## Interface

- WIDTH, 32, operand and HI/LO width (even, ≥ 8)
- MULT_CYCLES, 5, cycles busy stays high for mult/madd/msub class (≥ 1)
- DIV_CYCLES, 10, cycles busy stays high for div class (≥ 1)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  issue op this cycle (EX stage, instruction valid)
- op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10–15 no-op
- src_a  input  WIDTH  rs operand (forwarded)
- src_b  input  WIDTH  rt operand (forwarded)
- cancel  input  1  abort in-flight op (flush)
- busy  output  1  long-latency op in progress
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO
- div_zero  output  1  one-cycle pulse: a DIV/DIVU with src_b == 0 completed

## Operation

- States: IDLE, RUN. Down-counter cnt, width ≥ clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- IDLE + start + op in 0–7 (and no cancel): compute result from src_a/src_b and current hi/lo, latch into pend_hi/pend_lo, load cnt with MULT_CYCLES (ops 0,1,4–7) or DIV_CYCLES (2,3), go RUN.
- RUN: cnt decrements each edge; on the edge where cnt reaches 0, write hi/lo from pending, return to IDLE.
- MTHI/MTLO (IDLE + start): write src_a to hi or lo on that edge; no busy, state stays IDLE.
- start while RUN: ignored (the stall unit keeps it from happening; bench checks ignore anyway).
- cancel while RUN: go IDLE on that edge; hi/lo unchanged; pending discarded. cancel in IDLE: no effect. start and cancel same cycle: cancel wins, op not issued.
- Arithmetic: MULT/MULTU → {hi,lo} = 2·WIDTH-bit product, signed or unsigned. MADD(U) → {hi,lo} += product; MSUB(U) → {hi,lo} −= product; modulo 2^(2·WIDTH), accumulator taken from hi/lo at issue.
- DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend. DIVU unsigned. Overflow (−2^(WIDTH−1) / −1): lo = −2^(WIDTH−1), hi = 0.
- Divide by zero: runs full DIV_CYCLES, hi/lo unchanged at completion, div_zero pulses on the completion cycle.
- Opcodes 10–15 with start: no state change.

## Timing

- Reset: state IDLE, cnt 0, busy 0, hi 0, lo 0, div_zero 0, pending 0. Reset mid-RUN aborts op, same values.
- Issue at edge N (start sampled high): busy = 1 from after edge N through edge N+L−1; after edge N+L busy = 0 and hi/lo show result (L = MULT_CYCLES or DIV_CYCLES).
- busy is registered; start itself is not reflected in busy in cycle N — stall logic must use start | busy.
- MTHI/MTLO result visible after edge N; back-to-back MTHI then MULT legal, MULT reads new hi.
- div_zero high exactly one cycle, after edge N+L.
- hi/lo never change while busy except by reset.

## Test plan

- Reset, then MULT src_a = 0xFFFFFFFE, src_b = 3 → busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; MULTU same operands → hi = 0x00000002, lo = 0xFFFFFFFA.
- DIV src_a = 0xFFFFFFF9 (−7), src_b = 2 → after 10 cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1 × 1 → hi = 1, lo = 0; then MSUB 1 × 2 → hi = 0, lo = 0xFFFFFFFE.
- DIVU 5 / 0 with hi = 0x11, lo = 0x22 → busy 10 cycles, div_zero pulses once, hi = 0x11, lo = 0x22.
- MULT issued, cancel in 3rd busy cycle → busy low next cycle, hi/lo unchanged; start+cancel same cycle → busy never rises.
- Reset asserted mid-DIV → hi = lo = 0, busy = 0 next cycle; second run with MULT_CYCLES = 1, DIV_CYCLES = 1, WIDTH = 16 repeats first two scenarios scaled.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit for the EX stage.
// Long ops are computed when they issue, parked in pending registers, and
// committed to HI/LO once the latency counter expires. Cancel or reset while
// running drops the pending result.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic             dz_q, dz_d;

    logic [2*WIDTH-1:0] acc, a_ext, b_ext, prod, res;
    logic               res_dz;

    // Signed divide returning {remainder, quotient}; the most-negative / -1
    // case is pinned to quotient = most-negative, remainder = 0.
    function automatic logic [2*WIDTH-1:0] sdiv(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa, sb, q, r;
        sa = $signed(a);
        sb = $signed((b == '0) ? ONE : b);
        if (a == MIN_NEG && b == '1) begin
            q = $signed(MIN_NEG);
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    // Unsigned divide returning {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] udiv(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] bs;
        bs = (b == '0) ? ONE : b;
        return {a % bs, a / bs};
    endfunction

    // Issue-time datapath: one shared multiplier fed with sign- or
    // zero-extended operands (op[0] selects unsigned), plus the divider.
    always_comb begin
        acc    = {hi_q, lo_q};
        a_ext  = op[0] ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{src_a[WIDTH-1]}}, src_a};
        b_ext  = op[0] ? {{WIDTH{1'b0}}, src_b} : {{WIDTH{src_b[WIDTH-1]}}, src_b};
        prod   = a_ext * b_ext;
        res    = acc;
        res_dz = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            OP_DIV: begin
                if (src_b == '0) res_dz = 1'b1;
                else             res    = sdiv(src_a, src_b);
            end
            OP_DIVU: begin
                if (src_b == '0) res_dz = 1'b1;
                else             res    = udiv(src_a, src_b);
            end
            default: res = acc;
        endcase
    end

    // Control FSM: issue, count down, commit on expiry, abort on cancel.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        dz_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (op <= OP_MSUBU) begin
                        pend_hi_d = res[2*WIDTH-1:WIDTH];
                        pend_lo_d = res[WIDTH-1:0];
                        pend_dz_d = res_dz;
                        cnt_d     = (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES)
                                                                    : CW'(MULT_CYCLES);
                        state_d   = RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (op == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pend_hi_d = '0;
                    pend_lo_d = '0;
                    pend_dz_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        if (pend_dz_q) begin
                            dz_d = 1'b1;
                        end else begin
                            hi_d = pend_hi_q;
                            lo_d = pend_lo_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a 32-bit default instance and a 16-bit single-cycle
// instance, driven from vector tables through a scoreboard queue, plus
// hand-written cancel / reset / back-to-back sequences.
module tb_md_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, start_b, cancel;
    logic [3:0]  op;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic        busy32, dz32, busy16, dz16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u32 (
        .clk(clk), .reset(reset), .start(start_a), .op(op), .src_a(a32), .src_b(b32),
        .cancel(cancel), .busy(busy32), .hi(hi32), .lo(lo32), .div_zero(dz32));

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) u16 (
        .clk(clk), .reset(reset), .start(start_b), .op(op), .src_a(a16), .src_b(b16),
        .cancel(cancel), .busy(busy16), .hi(hi16), .lo(lo16), .div_zero(dz16));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, ehi, elo;
        logic        edz;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] ehi, elo;
        logic        edz;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t t32[16];
    vec_t t16[6];

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input logic dz,
                                input int lat, input string n);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.ehi = h; v.elo = l; v.edz = dz; v.lat = lat; v.name = n;
        return v;
    endfunction

    function automatic logic [31:0] get_hi(input int w);
        return (w == 0) ? hi32 : {16'h0, hi16};
    endfunction
    function automatic logic [31:0] get_lo(input int w);
        return (w == 0) ? lo32 : {16'h0, lo16};
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? busy32 : busy16;
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 0) ? dz32 : dz16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one vector, count busy cycles, then pop and compare the scoreboard entry.
    task automatic run_vec(input int w, input vec_t v);
        logic [31:0] hi0, lo0;
        int   cyc, dzc;
        logic stable;
        exp_t e;
        @(negedge clk);
        hi0 = get_hi(w);
        lo0 = get_lo(w);
        op  = v.op;
        if (w == 0) begin a32 = v.a; b32 = v.b; start_a = 1'b1; end
        else        begin a16 = v.a[15:0]; b16 = v.b[15:0]; start_b = 1'b1; end
        e.ehi = v.ehi; e.elo = v.elo; e.edz = v.edz; e.lat = v.lat; e.name = v.name;
        sb.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0; dzc = 0; stable = 1'b1;
        while (get_busy(w) && cyc < 64) begin
            cyc++;
            if (get_hi(w) !== hi0 || get_lo(w) !== lo0) stable = 1'b0;
            if (get_dz(w)) dzc++;
            @(negedge clk);
        end
        e = sb.pop_front();
        if (cyc >= 64) $display("FAIL %s timeout: busy stuck after %0d cycles, expected %0d", e.name, cyc, e.lat);
        check($sformatf("%s latency", e.name), 32'(cyc), 32'(e.lat));
        check($sformatf("%s hi", e.name), get_hi(w), e.ehi);
        check($sformatf("%s lo", e.name), get_lo(w), e.elo);
        check($sformatf("%s div_zero", e.name), {31'b0, get_dz(w)}, {31'b0, e.edz});
        check($sformatf("%s hilo stable while busy", e.name), {31'b0, stable}, 32'd1);
        check($sformatf("%s early div_zero", e.name), 32'(dzc), 32'd0);
        @(negedge clk);
        check($sformatf("%s div_zero one cycle", e.name), {31'b0, get_dz(w)}, 32'd0);
    endtask

    task automatic issue32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; a32 = a; b32 = b; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_idle32(input string name);
        int cyc;
        cyc = 0;
        while (busy32 && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (busy32) begin
            errors++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles, expected 0", name, cyc);
        end
    endtask

    initial begin
        logic seen;

        t32[0]  = mk(4'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5, "mult");
        t32[1]  = mk(4'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, 5, "multu");
        t32[2]  = mk(4'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10, "div -7/2");
        t32[3]  = mk(4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 10, "div ovf");
        t32[4]  = mk(4'd8, 32'h0, 32'h0, 32'h0, 32'h80000000, 1'b0, 0, "mthi 0");
        t32[5]  = mk(4'd9, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 0, "mtlo");
        t32[6]  = mk(4'd5, 32'd1, 32'd1, 32'h1, 32'h0, 1'b0, 5, "maddu carry");
        t32[7]  = mk(4'd6, 32'd1, 32'd2, 32'h0, 32'hFFFFFFFE, 1'b0, 5, "msub borrow");
        t32[8]  = mk(4'd3, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0, 10, "divu 7/2");
        t32[9]  = mk(4'd4, 32'hFFFFFFFF, 32'd3, 32'h1, 32'h0, 1'b0, 5, "madd neg");
        t32[10] = mk(4'd8, 32'h11, 32'h0, 32'h11, 32'h0, 1'b0, 0, "mthi 11");
        t32[11] = mk(4'd9, 32'h22, 32'h0, 32'h11, 32'h22, 1'b0, 0, "mtlo 22");
        t32[12] = mk(4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 10, "divu by zero");
        t32[13] = mk(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h13, 32'h21, 1'b0, 5, "msubu max");
        t32[14] = mk(4'd2, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 10, "div 7/-2");
        t32[15] = mk(4'd12, 32'h1234, 32'h5678, 32'h1, 32'hFFFFFFFD, 1'b0, 0, "nop op12");

        t16[0] = mk(4'd0, 32'hFFFE, 32'd3, 32'hFFFF, 32'hFFFA, 1'b0, 1, "w16 mult");
        t16[1] = mk(4'd1, 32'hFFFE, 32'd3, 32'h0002, 32'hFFFA, 1'b0, 1, "w16 multu");
        t16[2] = mk(4'd2, 32'hFFF9, 32'd2, 32'hFFFF, 32'hFFFD, 1'b0, 1, "w16 div -7/2");
        t16[3] = mk(4'd2, 32'h8000, 32'hFFFF, 32'h0, 32'h8000, 1'b0, 1, "w16 div ovf");
        t16[4] = mk(4'd3, 32'd5, 32'd0, 32'h0, 32'h8000, 1'b1, 1, "w16 divu by zero");
        t16[5] = mk(4'd4, 32'hFFFF, 32'hFFFF, 32'h0, 32'h8001, 1'b0, 1, "w16 madd");

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; cancel = 1'b0;
        op = 4'd0; a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'b0, busy32}, 32'd0);
        check("reset hi", hi32, 32'd0);
        check("reset lo", lo32, 32'd0);
        check("reset div_zero", {31'b0, dz32}, 32'd0);
        check("reset w16 hi", {16'h0, hi16}, 32'd0);
        check("reset w16 busy", {31'b0, busy16}, 32'd0);

        for (int i = 0; i < 16; i++) run_vec(0, t32[i]);

        // Cancel in the third busy cycle: HI/LO keep the MTHI/MTLO values.
        issue32(4'd8, 32'hAA, 32'h0);
        issue32(4'd9, 32'hBB, 32'h0);
        issue32(4'd0, 32'd3, 32'd4);
        check("cancel busy cycle1", {31'b0, busy32}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy drop", {31'b0, busy32}, 32'd0);
        check("cancel hi", hi32, 32'hAA);
        repeat (6) @(negedge clk);
        check("cancel lo later", lo32, 32'hBB);
        check("cancel hi later", hi32, 32'hAA);

        // Start and cancel together: never issues.
        @(negedge clk);
        op = 4'd0; a32 = 32'd3; b32 = 32'd4; start_a = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start_a = 1'b0; cancel = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy32) seen = 1'b1;
            @(negedge clk);
        end
        check("start+cancel busy", {31'b0, seen}, 32'd0);
        check("start+cancel lo", lo32, 32'hBB);

        // Start while running is ignored.
        issue32(4'd0, 32'd2, 32'd3);
        op = 4'd8; a32 = 32'h55; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle32("start in run");
        check("start in run hi", hi32, 32'h0);
        check("start in run lo", lo32, 32'h6);

        // MTHI immediately followed by MADDU uses the new HI.
        @(negedge clk);
        op = 4'd8; a32 = 32'h2; start_a = 1'b1;
        @(negedge clk);
        op = 4'd5; a32 = 32'd1; b32 = 32'd1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle32("mthi then maddu");
        check("mthi then maddu hi", hi32, 32'h2);
        check("mthi then maddu lo", lo32, 32'h7);

        // Reset in the middle of a divide.
        issue32(4'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset mid div busy", {31'b0, busy32}, 32'd0);
        check("reset mid div hi", hi32, 32'd0);
        check("reset mid div lo", lo32, 32'd0);
        repeat (12) @(negedge clk);
        check("reset mid div no late commit", lo32, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(1, t16[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
